// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and its controller / gate under test.
// master drives requests and the gate output; slave is the sweeper itself.
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;
    logic       unstable;

    modport master (
        output start, abort, expected, dut_out,
        input  in1, in2, in3, busy, done, table_out, match, unstable
    );

    modport slave (
        input  start, abort, expected, dut_out,
        output in1, in2, in3, busy, done, table_out, match, unstable
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 input combinations of a 3-input gate, settles, samples and compares its table.
// Define TT_STABILITY_CHECK_EN to flag dut_out changing on the final settle cycle.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] table_q, table_d;
    logic       match_q, match_d;
    logic       done_q, done_d;
    logic       accept;

    assign accept = (state_q == ST_IDLE) && bus.start && !bus.abort;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        match_d = match_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETTLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    table_d = 8'd0;
                    match_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    match_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    match_d = 1'b0;
                end else begin
                    // idx 0 (inputs 000) lands in the table MSB
                    table_d[3'd7 - idx_q] = bus.dut_out;
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = 8'd0;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // abort is deliberately ignored here; the sweep is already complete
                done_d  = 1'b1;
                match_d = (table_q == bus.expected);
                idx_d   = 3'd0;
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            table_q <= 8'd0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    assign {bus.in1, bus.in2, bus.in3} = idx_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.match     = match_q;

`ifdef TT_STABILITY_CHECK_EN
    logic prev_q;
    logic unstable_q, unstable_d;

    always_comb begin
        unstable_d = unstable_q;
        if (accept) begin
            unstable_d = 1'b0;
        end else if ((state_q == ST_SETTLE) && !bus.abort && (cnt_q == CNT_LAST) &&
                     (bus.dut_out != prev_q)) begin
            unstable_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= 1'b0;
            unstable_q <= 1'b0;
        end else begin
            prev_q     <= bus.dut_out;
            unstable_q <= unstable_d;
        end
    end

    assign bus.unstable = unstable_q;
`else
    assign bus.unstable = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper against a position-in-sweep reference model.
module tb_truth_table_sweeper;

    localparam int unsigned S  = 4;
    localparam int unsigned SW = 8 * (S + 1);
`ifdef TT_STABILITY_CHECK_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gate_tt;
    logic       glitch;
    int         n_tests = 0;
    int         n_fail  = 0;

    truth_table_sweeper_if bus ();

    truth_table_sweeper #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ideal gate described by its own truth table, with an optional injected glitch
    assign bus.dut_out = gate_tt[3'd7 - {bus.in1, bus.in2, bus.in3}] ^ glitch;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is a run of 8 slots of S+1 cycles each, the last cycle of
    // a slot being the sample; m_t counts cycles since the accepting edge.
    bit          m_active = 1'b0;
    int unsigned m_t      = 0;
    logic [7:0]  m_table  = 8'd0;
    logic        m_match  = 1'b0;
    logic        m_done   = 1'b0;
    logic        m_unst   = 1'b0;
    logic        m_prev   = 1'b0;
    logic [2:0]  m_in;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_table  <= 8'd0;
            m_match  <= 1'b0;
            m_done   <= 1'b0;
            m_unst   <= 1'b0;
            m_prev   <= 1'b0;
        end else begin
            m_prev <= bus.dut_out;
            m_done <= 1'b0;
            if (!m_active) begin
                if (bus.start && !bus.abort) begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                    m_table  <= 8'd0;
                    m_match  <= 1'b0;
                    m_unst   <= 1'b0;
                end
            end else if (m_t == SW) begin
                m_done   <= 1'b1;
                m_match  <= (m_table == bus.expected);
                m_active <= 1'b0;
            end else if (bus.abort) begin
                m_active <= 1'b0;
                m_match  <= 1'b0;
            end else begin
                if (m_t % (S + 1) == S) m_table[7 - m_t / (S + 1)] <= bus.dut_out;
                if (STAB && (m_t % (S + 1) == S - 1) && (bus.dut_out != m_prev)) m_unst <= 1'b1;
                m_t <= m_t + 1;
            end
        end
    end

    always_comb begin
        m_in = 3'd0;
        if (m_active) m_in = (m_t / (S + 1) > 7) ? 3'd7 : 3'(m_t / (S + 1));
    end

    always @(negedge clk) begin
        check("busy", 8'(bus.busy), 8'(m_active));
        check("done", 8'(bus.done), 8'(m_done));
        check("in", 8'({bus.in1, bus.in2, bus.in3}), 8'(m_in));
        check("table_out", bus.table_out, m_table);
        check("match", 8'(bus.match), 8'(m_match));
        check("unstable", 8'(bus.unstable), 8'(m_unst));
    end

    task automatic pulse_start();
        @(negedge clk);
        #1 bus.start = 1'b1;
        @(negedge clk);
        #1 bus.start = 1'b0;
    endtask

    // cycles from the accepting edge until done is seen; bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 200);
    endtask

    int n;
    int ndone;
    int done_cyc;

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = 8'h57;
        gate_tt      = 8'h57;
        glitch       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 8'(bus.busy), 8'd0);
        check("reset_table", bus.table_out, 8'd0);

        // first start rides the edge right after reset release
        #1 rst_n = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        #1 bus.start = 1'b0;
        wait_done(n);
        check("latency_first", 8'(n), 8'd41);
        check("table_57", bus.table_out, 8'h57);
        check("match_57", 8'(bus.match), 8'd1);

        bus.expected = 8'hEA;
        pulse_start();
        wait_done(n);
        check("latency_ea", 8'(n), 8'd41);
        check("table_ea", bus.table_out, 8'h57);
        check("match_ea", 8'(bus.match), 8'd0);

        // abort ten cycles in
        bus.expected = 8'h57;
        pulse_start();
        repeat (9) @(negedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        check("abort_busy", 8'(bus.busy), 8'd0);
        check("abort_in", 8'({bus.in1, bus.in2, bus.in3}), 8'd0);
        check("abort_match", 8'(bus.match), 8'd0);
        #1 bus.abort = 1'b0;
        pulse_start();
        wait_done(n);
        check("after_abort_table", bus.table_out, 8'h57);

        // reset mid-sweep at idx 3
        pulse_start();
        n = 0;
        while ({bus.in1, bus.in2, bus.in3} != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx3", 8'({bus.in1, bus.in2, bus.in3}), 8'd3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_in", 8'({bus.in1, bus.in2, bus.in3}), 8'd0);
        check("rst_mid_table", bus.table_out, 8'd0);
        check("rst_mid_busy", 8'(bus.busy), 8'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        wait_done(n);
        check("latency_after_rst", 8'(n), 8'd41);

        // start re-pulsed at cycles 5 and 20 of a sweep
        pulse_start();
        ndone    = 0;
        done_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                done_cyc = c;
            end
            #1 bus.start = (c == 4 || c == 19);
        end
        bus.start = 1'b0;
        check("repulse_ndone", 8'(ndone), 8'd1);
        check("repulse_cycle", 8'(done_cyc), 8'd41);

        // abort while in DONE still lets done pulse
        pulse_start();
        repeat (40) @(negedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        check("abort_in_done", 8'(bus.done), 8'd1);
        #1 bus.abort = 1'b0;

        // glitch on the last settle cycle of idx 2
        pulse_start();
        repeat (13) @(negedge clk);
        #1 glitch = 1'b1;
        @(negedge clk);
        #1 glitch = 1'b0;
        wait_done(n);
        check("glitch_unstable", 8'(bus.unstable), 8'(STAB));
        check("glitch_table", bus.table_out, 8'h57);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            rst_n     = ($urandom % 600) != 0;
            bus.start = ($urandom % 8) == 0;
            bus.abort = ($urandom % 40) == 0;
            glitch    = ($urandom % 12) == 0;
            if (!m_active) begin
                if ($urandom % 4 == 0) gate_tt = 8'($urandom);
                bus.expected = ($urandom % 2 == 0) ? gate_tt : 8'($urandom);
            end
        end
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        glitch    = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, range 1..255: cycles each input combination is held before the output is sampled.
REQ-002 SHALL have port clk  input  1  single clock; every register updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a sweep in progress.
REQ-006 SHALL have port expected  input  8  reference truth table, compared when the sweep ends.
REQ-007 SHALL have port dut_out  input  1  output of the 3-input gate under test.
REQ-008 SHALL have ports in1, in2, in3  output  1 each  registered drive of the gate's inputs.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-011 SHALL have port table_out  output  8  captured truth table.
REQ-012 SHALL have port match  output  1  table_out equals expected, valid from done.
REQ-013 SHALL have port unstable  output  1  a settle-window glitch was seen (see Configuration).

Function
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE: when start=1 and abort=0, SHALL go to SETTLE with idx=0, cnt=0, table_out=0, match=0 and unstable=0.
REQ-016 SHALL drive {in1,in2,in3} from the registered idx, with in1 as MSB; the drive SHALL change on the same edge as idx.
REQ-017 SETTLE: SHALL increment cnt each cycle and go to SAMPLE on the cycle where cnt==SETTLE_CYCLES-1.
REQ-018 SAMPLE: SHALL write table_out[7-idx] <= dut_out, so {in1,in2,in3}=000 maps to bit 7 and 111 maps to bit 0.
REQ-019 SAMPLE: if idx<7, SHALL set idx<=idx+1, cnt<=0 and go to SETTLE; if idx==7, SHALL go to DONE.
REQ-020 DONE: SHALL assert done for exactly one cycle, register match <= (table_out==expected), and go to IDLE.
REQ-021 busy SHALL be high in SETTLE, SAMPLE and DONE, and low in IDLE.
REQ-022 Latency from the start-accept edge to done high SHALL be 8*(SETTLE_CYCLES+1)+1 cycles.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge: idx=0, in*=0, done not pulsed, table_out holds partial bits, match=0.
REQ-025 abort and start in the same IDLE cycle: abort SHALL win and the block SHALL stay in IDLE.
REQ-026 abort during DONE SHALL be ignored; done still pulses.
REQ-027 table_out and match SHALL hold their values in IDLE until the next accepted start.
REQ-028 idx SHALL NOT wrap; the sweep ends after idx 7.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, idx=0, cnt=0, in1=in2=in3=0, busy=0, done=0, table_out=0, match=0 and unstable=0.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-031 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro TT_STABILITY_CHECK_EN SHALL control the stability checker.
REQ-033 With TT_STABILITY_CHECK_EN defined: in SETTLE, if dut_out differs from its previous-cycle value on the final settle cycle, unstable SHALL set; it SHALL be sticky until the next accepted start or reset.
REQ-034 With TT_STABILITY_CHECK_EN defined and SETTLE_CYCLES=1: the check SHALL compare against the value sampled in the preceding cycle.
REQ-035 Without TT_STABILITY_CHECK_EN: unstable SHALL be constant 0 and no checker logic SHALL be present.

Verification
REQ-036 SETTLE_CYCLES=4, ideal 0x57 gate model, expected=0x57, pulse start -> done 41 cycles later; table_out=0x57, match=1.
REQ-037 Same stimulus with expected=0xEA -> table_out=0x57, match=0.
REQ-038 abort asserted 10 cycles after start -> IDLE next edge, no done pulse, in*=000, match=0; a fresh start -> full sweep, table_out=0x57.
REQ-039 rst_n pulled low mid-sweep at idx=3 -> all outputs 0 immediately; after release, start -> a normal 41-cycle sweep.
REQ-040 start re-pulsed at cycles 5 and 20 of a sweep -> ignored; exactly one done at cycle 41.
REQ-041 With TT_STABILITY_CHECK_EN defined, dut_out toggled on the last settle cycle of idx 2 -> unstable=1 and held through done; without the macro -> unstable=0.
